cd_spi_slave: RTL and testbench
===============================

# cd_spi_slave

SPI-slave front end that drives the CDBUS controller's 8-bit CSR bus from an external host MCU. Oversamples SPI (mode 0, MSB first) in the system clock domain, decodes a one-byte header (R/W + 5-bit register address), then issues one `csr_read` or `csr_write` pulse per data byte. Generates the `chip_select` the CSR block uses for burst framing. Sits between the board-level SPI pins and the CSR register file.

## Interface
- `SYNC_STAGES`, 2: synchronizer depth for `spi_sck`, `spi_nss`, `spi_mosi` (≥2).
- `clk`  in  1: system clock; SCK frequency ≤ clk/8.
- `reset_n`  in  1: asynchronous, active-low reset.
- `spi_sck`  in  1: SPI clock, idle low (mode 0).
- `spi_nss`  in  1: SPI select, active low.
- `spi_mosi`  in  1: host → slave data.
- `spi_miso`  out  1: slave → host data.
- `spi_miso_oe`  out  1: MISO tri-state enable; 1 while selected.
- `chip_select`  out  1: synchronized, inverted `spi_nss`.
- `csr_address`  out  5: register address from header.
- `csr_read`  out  1: one-cycle read strobe.
- `csr_readdata`  in  8: combinational read data for `csr_address`.
- `csr_write`  out  1: one-cycle write strobe.
- `csr_writedata`  out  8: assembled write byte.

## Operation
- Frame = NSS low; byte 0 header: bit7 = 1 write / 0 read, bits 6:5 ignored, bits 4:0 address. Bytes 1..N data. Address never auto-increments; all data bytes of a frame target the same register (burst DAT / INT_FLAG_L shift reads).
- States: IDLE (nss_s high), HEADER, WR_DATA, RD_DATA.
  - IDLE → HEADER on nss_s falling; bit_cnt = 0.
  - HEADER: on each detected SCK rise shift `mosi_s` in; on 8th rise latch `csr_address`, go WR_DATA or RD_DATA.
  - WR_DATA: shift 8 bits; on 8th rise drive `csr_writedata` = byte, pulse `csr_write`; stay.
  - RD_DATA: at bit 0 of each byte MISO = live `csr_readdata[7]`; on 1st SCK rise of the byte pulse `csr_read`, load shift reg from `csr_readdata`; on each SCK fall shift left, MISO = shreg[7]; no read after the final byte.
  - Any state → IDLE when nss_s high; partial byte discarded, no strobe.
- MISO = 0 in IDLE/HEADER/WR_DATA. `spi_miso_oe` = `chip_select`.
- bit_cnt 3-bit, wraps 7 → 0 at byte boundary.

## Timing
- Reset: all outputs 0; state IDLE; bit_cnt 0; shift regs 0.
- Input latency: `SYNC_STAGES` clk; SCK edges detected on synchronized signal (one cycle per edge).
- `csr_write` high exactly 1 clk, the cycle after the 8th rise detection; `csr_address`/`csr_writedata` stable in that cycle.
- `csr_read` high exactly 1 clk, the cycle after 1st rise detection of a read byte; `csr_readdata` sampled in that same cycle.
- `chip_select` falls `SYNC_STAGES` clk after NSS rises; a strobe scheduled in that cycle is suppressed.
- NSS deassert coinciding with 8th rise detection: byte completes, strobe issued, then IDLE.
- Reset asserted mid-frame: immediate return to reset values; next frame needs fresh NSS falling edge.
- Back-to-back strobes ≥ 8 clk apart (guaranteed by SCK ≤ clk/8).

## Structure
- Package `cd_spi_pkg`: state enum, header field positions (`HDR_WR_BIT` = 7, `HDR_ADDR_MSB` = 4), `CSR_AW` = 5.
- Sub-module `cd_sync`: `SYNC_STAGES`-deep flop synchronizer, instantiated for SCK, NSS, MOSI.
- FSM, bit counter, and shift registers in `cd_spi_slave`; target ~200 lines.

## Test plan
- Write frame 0x82, 0x85 (addr 0x02, data 0x85) → one `csr_write` with address 0x02, writedata 0x85; no `csr_read`.
- Read frame 0x00 + 1 dummy byte, `csr_readdata` = 0x0f → MISO shifts 0x0f; exactly one `csr_read`.
- Burst read 0x15 + 4 bytes from a model FIFO returning 0x11,0x22,0x33,0x44 → MISO bytes match; exactly 4 `csr_read` pulses, all at address 0x15.
- Burst write 0x95 + 0xaa,0x55,0x01 → 3 `csr_write` pulses at 0x15 with those data in order.
- NSS raised after 5 bits of a write data byte → no `csr_write`; `chip_select` 0; next frame decodes normally.
- `reset_n` pulsed mid read burst → all outputs 0 immediately; post-reset frame 0x8b, 0x7e → single write 0x7e at 0x0b.

Source files
------------

// File: rtl/cd_spi_pkg.sv
// Shared types and field positions for the CDBUS SPI-slave CSR front end.
package cd_spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HEADER  = 2'd1,
    ST_WR_DATA = 2'd2,
    ST_RD_DATA = 2'd3
  } state_e;

  localparam int unsigned CSR_AW       = 5;
  localparam int unsigned CSR_DW       = 8;
  localparam int unsigned BIT_CNT_W    = 3;
  localparam int unsigned HDR_WR_BIT   = 7;
  localparam int unsigned HDR_ADDR_MSB = 4;

endpackage

// File: rtl/cd_sync.sv
// Multi-flop synchronizer bringing one asynchronous pin into the clk domain.
module cd_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_sync <= '0;
    else          r_sync <= {r_sync[STAGES-2:0], i_d};
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/cd_spi_slave.sv
// SPI mode-0 slave that turns a header byte plus data bytes into CSR read/write strobes.
// SPI pins are oversampled in the clk domain; all strobes target the header address.
module cd_spi_slave
  import cd_spi_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              spi_sck,
  input  logic              spi_nss,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              spi_miso_oe,
  output logic              chip_select,
  output logic [CSR_AW-1:0] csr_address,
  output logic              csr_read,
  input  logic [CSR_DW-1:0] csr_readdata,
  output logic              csr_write,
  output logic [CSR_DW-1:0] csr_writedata
);

  logic w_sck_s;
  logic w_nss_s;
  logic w_mosi_s;

  cd_sync #(.STAGES(SYNC_STAGES)) u_sync_sck (
    .clk(clk), .reset_n(reset_n), .i_d(spi_sck), .o_q(w_sck_s)
  );
  cd_sync #(.STAGES(SYNC_STAGES)) u_sync_nss (
    .clk(clk), .reset_n(reset_n), .i_d(spi_nss), .o_q(w_nss_s)
  );
  cd_sync #(.STAGES(SYNC_STAGES)) u_sync_mosi (
    .clk(clk), .reset_n(reset_n), .i_d(spi_mosi), .o_q(w_mosi_s)
  );

  state_e                r_state, w_state_nxt;
  logic [BIT_CNT_W-1:0]  r_bit_cnt, w_bit_cnt_nxt;
  logic [CSR_DW-2:0]     r_shreg, w_shreg_nxt;
  logic [CSR_DW-1:0]     r_rd_shreg, w_rd_shreg_nxt;
  logic                  r_miso, w_miso_nxt;
  logic                  r_csr_read, w_read_nxt;
  logic                  r_csr_write, w_write_nxt;
  logic [CSR_AW-1:0]     r_csr_address, w_address_nxt;
  logic [CSR_DW-1:0]     r_csr_writedata, w_writedata_nxt;
  logic                  r_sck_d;
  logic                  r_armed;

  logic                  w_sel;
  logic                  w_sck_rise;
  logic                  w_sck_fall;
  logic                  w_byte_done;
  logic [CSR_DW-1:0]     w_byte;

  // Select only counts once NSS has been seen high since reset, so a frame
  // interrupted by reset is ignored until the host issues a fresh falling edge.
  assign w_sel       = r_armed & ~w_nss_s;
  assign w_sck_rise  = w_sck_s & ~r_sck_d;
  assign w_sck_fall  = ~w_sck_s & r_sck_d;
  assign w_byte      = {r_shreg, w_mosi_s};
  assign w_byte_done = w_sck_rise && (r_bit_cnt == BIT_CNT_W'(CSR_DW - 1));

  always_comb begin
    w_state_nxt     = r_state;
    w_bit_cnt_nxt   = r_bit_cnt;
    w_shreg_nxt     = r_shreg;
    w_rd_shreg_nxt  = r_rd_shreg;
    w_miso_nxt      = 1'b0;
    w_read_nxt      = 1'b0;
    w_write_nxt     = 1'b0;
    w_address_nxt   = r_csr_address;
    w_writedata_nxt = r_csr_writedata;

    // Read data is captured in the same cycle the read strobe is presented.
    if (r_csr_read) w_rd_shreg_nxt = csr_readdata;

    unique case (r_state)
      ST_IDLE: begin
        w_bit_cnt_nxt = '0;
        if (w_sel) w_state_nxt = ST_HEADER;
      end

      ST_HEADER, ST_WR_DATA: begin
        if (w_sck_rise) begin
          w_shreg_nxt   = w_byte[CSR_DW-2:0];
          w_bit_cnt_nxt = r_bit_cnt + BIT_CNT_W'(1);
          if (w_byte_done) begin
            if (r_state == ST_HEADER) begin
              w_address_nxt = w_byte[HDR_ADDR_MSB:0];
              w_state_nxt   = w_byte[HDR_WR_BIT] ? ST_WR_DATA : ST_RD_DATA;
            end else begin
              w_write_nxt     = 1'b1;
              w_writedata_nxt = w_byte;
            end
          end
        end
        // A byte completing as NSS rises still issues its write strobe.
        if (!w_sel) begin
          w_state_nxt   = ST_IDLE;
          w_bit_cnt_nxt = '0;
        end
      end

      ST_RD_DATA: begin
        w_miso_nxt = r_miso;
        if (r_bit_cnt == '0) w_miso_nxt = csr_readdata[CSR_DW-1];
        if (w_sck_rise) begin
          w_bit_cnt_nxt = r_bit_cnt + BIT_CNT_W'(1);
          if (r_bit_cnt == '0) w_read_nxt = 1'b1;
        end
        if (w_sck_fall && (r_bit_cnt != '0)) begin
          w_rd_shreg_nxt = {r_rd_shreg[CSR_DW-2:0], 1'b0};
          w_miso_nxt     = r_rd_shreg[CSR_DW-2];
        end
        if (!w_sel) begin
          w_state_nxt   = ST_IDLE;
          w_bit_cnt_nxt = '0;
          w_read_nxt    = 1'b0;
          w_miso_nxt    = 1'b0;
        end
      end

      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state         <= ST_IDLE;
      r_bit_cnt       <= '0;
      r_shreg         <= '0;
      r_rd_shreg      <= '0;
      r_miso          <= 1'b0;
      r_csr_read      <= 1'b0;
      r_csr_write     <= 1'b0;
      r_csr_address   <= '0;
      r_csr_writedata <= '0;
      r_sck_d         <= 1'b0;
      r_armed         <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_bit_cnt       <= w_bit_cnt_nxt;
      r_shreg         <= w_shreg_nxt;
      r_rd_shreg      <= w_rd_shreg_nxt;
      r_miso          <= w_miso_nxt;
      r_csr_read      <= w_read_nxt;
      r_csr_write     <= w_write_nxt;
      r_csr_address   <= w_address_nxt;
      r_csr_writedata <= w_writedata_nxt;
      r_sck_d         <= w_sck_s;
      if (w_nss_s) r_armed <= 1'b1;
    end
  end

  assign spi_miso      = r_miso;
  assign spi_miso_oe   = w_sel;
  assign chip_select   = w_sel;
  assign csr_address   = r_csr_address;
  assign csr_read      = r_csr_read;
  assign csr_write     = r_csr_write;
  assign csr_writedata = r_csr_writedata;

endmodule

// File: tb/tb_cd_spi_slave.sv
// Directed bench for cd_spi_slave: SPI host driver, CSR read FIFO model and strobe logger.
module tb_cd_spi_slave;

  localparam int HALF = 6;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       spi_sck;
  logic       spi_nss;
  logic       spi_mosi;
  logic       spi_miso;
  logic       spi_miso_oe;
  logic       chip_select;
  logic [4:0] csr_address;
  logic       csr_read;
  logic [7:0] csr_readdata;
  logic       csr_write;
  logic [7:0] csr_writedata;

  int checks   = 0;
  int failures = 0;

  cd_spi_slave #(.SYNC_STAGES(2)) dut (
    .clk(clk), .reset_n(reset_n),
    .spi_sck(spi_sck), .spi_nss(spi_nss), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe), .chip_select(chip_select),
    .csr_address(csr_address), .csr_read(csr_read), .csr_readdata(csr_readdata),
    .csr_write(csr_write), .csr_writedata(csr_writedata)
  );

  always #5 clk = ~clk;

  // Read FIFO model: each read strobe pops one entry.
  logic [7:0] fifo [8];
  int         pop_cnt = 0;
  int         fifo_base = 0;
  logic [2:0] fifo_idx;
  assign fifo_idx     = 3'(pop_cnt - fifo_base);
  assign csr_readdata = fifo[fifo_idx];
  always @(posedge clk) if (csr_read) pop_cnt <= pop_cnt + 1;

  // Strobe logger, sampled mid-cycle.
  int         wr_cnt = 0;
  int         rd_cnt = 0;
  logic [4:0] wr_addr_log [64];
  logic [7:0] wr_data_log [64];
  logic [4:0] rd_addr_log [64];
  always @(negedge clk) begin
    if (csr_write && wr_cnt < 64) begin
      wr_addr_log[wr_cnt] = csr_address;
      wr_data_log[wr_cnt] = csr_writedata;
    end
    if (csr_read && rd_cnt < 64) rd_addr_log[rd_cnt] = csr_address;
    if (csr_write) wr_cnt++;
    if (csr_read)  rd_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = '0;
    for (int i = 7; i >= 8 - nbits; i--) begin
      spi_mosi = tx[i];
      repeat (HALF) @(negedge clk);
      rx[i] = spi_miso;
      spi_sck = 1'b1;
      repeat (HALF) @(negedge clk);
      spi_sck = 1'b0;
    end
  endtask

  task automatic frame_start;
    spi_nss = 1'b0;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic frame_end;
    repeat (HALF) @(negedge clk);
    spi_nss = 1'b1;
    repeat (4 * HALF) @(negedge clk);
  endtask

  logic [7:0] rx;
  int         wr0, rd0;
  logic [7:0] exp_rd [4];
  logic [7:0] exp_wr [3];

  initial begin
    reset_n  = 1'b0;
    spi_sck  = 1'b0;
    spi_nss  = 1'b1;
    spi_mosi = 1'b0;
    for (int i = 0; i < 8; i++) fifo[i] = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_chip_select", 32'(chip_select), 0);
    chk("rst_miso_oe", 32'(spi_miso_oe), 0);
    chk("rst_miso", 32'(spi_miso), 0);
    chk("rst_csr_read", 32'(csr_read), 0);
    chk("rst_csr_write", 32'(csr_write), 0);
    chk("rst_csr_address", 32'(csr_address), 0);
    chk("rst_csr_writedata", 32'(csr_writedata), 0);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);

    // Single write: addr 0x02, data 0x85.
    wr0 = wr_cnt; rd0 = rd_cnt;
    frame_start();
    chk("wr1_chip_select", 32'(chip_select), 1);
    chk("wr1_miso_oe", 32'(spi_miso_oe), 1);
    spi_bits(8'h82, 8, rx);
    spi_bits(8'h85, 8, rx);
    chk("wr1_miso_low", 32'(spi_miso), 0);
    frame_end();
    chk("wr1_count", 32'(wr_cnt - wr0), 1);
    chk("wr1_addr", 32'(wr_addr_log[wr0]), 32'h02);
    chk("wr1_data", 32'(wr_data_log[wr0]), 32'h85);
    chk("wr1_no_read", 32'(rd_cnt - rd0), 0);
    chk("wr1_cs_idle", 32'(chip_select), 0);

    // Single read of 0x0f from addr 0x00.
    fifo_base = pop_cnt;
    fifo[0] = 8'h0f; fifo[1] = 8'hff;
    wr0 = wr_cnt; rd0 = rd_cnt;
    frame_start();
    spi_bits(8'h00, 8, rx);
    spi_bits(8'h00, 8, rx);
    chk("rd1_miso_byte", 32'(rx), 32'h0f);
    frame_end();
    chk("rd1_count", 32'(rd_cnt - rd0), 1);
    chk("rd1_addr", 32'(rd_addr_log[rd0]), 32'h00);
    chk("rd1_no_write", 32'(wr_cnt - wr0), 0);
    chk("rd1_miso_idle", 32'(spi_miso), 0);

    // Burst read at 0x15 from the FIFO model.
    exp_rd[0] = 8'h11; exp_rd[1] = 8'h22; exp_rd[2] = 8'h33; exp_rd[3] = 8'h44;
    fifo_base = pop_cnt;
    for (int i = 0; i < 4; i++) fifo[i] = exp_rd[i];
    fifo[4] = 8'hee;
    rd0 = rd_cnt;
    frame_start();
    spi_bits(8'h15, 8, rx);
    for (int b = 0; b < 4; b++) begin
      spi_bits(8'h00, 8, rx);
      chk($sformatf("rdb_byte%0d", b), 32'(rx), 32'(exp_rd[b]));
    end
    frame_end();
    chk("rdb_count", 32'(rd_cnt - rd0), 4);
    for (int b = 0; b < 4; b++)
      chk($sformatf("rdb_addr%0d", b), 32'(rd_addr_log[rd0 + b]), 32'h15);

    // Burst write at 0x15.
    exp_wr[0] = 8'haa; exp_wr[1] = 8'h55; exp_wr[2] = 8'h01;
    wr0 = wr_cnt; rd0 = rd_cnt;
    frame_start();
    spi_bits(8'h95, 8, rx);
    for (int b = 0; b < 3; b++) spi_bits(exp_wr[b], 8, rx);
    frame_end();
    chk("wrb_count", 32'(wr_cnt - wr0), 3);
    for (int b = 0; b < 3; b++) begin
      chk($sformatf("wrb_addr%0d", b), 32'(wr_addr_log[wr0 + b]), 32'h15);
      chk($sformatf("wrb_data%0d", b), 32'(wr_data_log[wr0 + b]), 32'(exp_wr[b]));
    end
    chk("wrb_no_read", 32'(rd_cnt - rd0), 0);

    // Aborted write byte after 5 bits, then a normal frame.
    wr0 = wr_cnt;
    frame_start();
    spi_bits(8'h83, 8, rx);
    spi_bits(8'hf0, 5, rx);
    frame_end();
    chk("abort_no_write", 32'(wr_cnt - wr0), 0);
    chk("abort_cs", 32'(chip_select), 0);
    frame_start();
    spi_bits(8'h84, 8, rx);
    spi_bits(8'h3c, 8, rx);
    frame_end();
    chk("abort_next_count", 32'(wr_cnt - wr0), 1);
    chk("abort_next_addr", 32'(wr_addr_log[wr0]), 32'h04);
    chk("abort_next_data", 32'(wr_data_log[wr0]), 32'h3c);

    // Reset mid read burst; MISO is high mid-byte when reset hits.
    fifo_base = pop_cnt;
    fifo[0] = 8'ha5; fifo[1] = 8'hff; fifo[2] = 8'hff;
    frame_start();
    spi_bits(8'h07, 8, rx);
    spi_bits(8'h00, 8, rx);
    chk("rst_mid_rx0", 32'(rx), 32'ha5);
    spi_bits(8'h00, 3, rx);
    chk("rst_mid_pre_miso", 32'(spi_miso), 1);
    chk("rst_mid_pre_addr", 32'(csr_address), 32'h07);
    #1 reset_n = 1'b0;
    #1;
    chk("rst_mid_chip_select", 32'(chip_select), 0);
    chk("rst_mid_miso_oe", 32'(spi_miso_oe), 0);
    chk("rst_mid_miso", 32'(spi_miso), 0);
    chk("rst_mid_csr_read", 32'(csr_read), 0);
    chk("rst_mid_csr_write", 32'(csr_write), 0);
    chk("rst_mid_csr_address", 32'(csr_address), 0);
    chk("rst_mid_csr_writedata", 32'(csr_writedata), 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    wr0 = wr_cnt; rd0 = rd_cnt;
    repeat (4) @(negedge clk);
    chk("post_rst_cs_held_low_nss", 32'(chip_select), 0);
    spi_bits(8'h8b, 8, rx);
    spi_bits(8'h12, 8, rx);
    chk("post_rst_stale_no_write", 32'(wr_cnt - wr0), 0);
    chk("post_rst_stale_no_read", 32'(rd_cnt - rd0), 0);
    frame_end();
    frame_start();
    spi_bits(8'h8b, 8, rx);
    spi_bits(8'h7e, 8, rx);
    frame_end();
    chk("post_rst_count", 32'(wr_cnt - wr0), 1);
    chk("post_rst_addr", 32'(wr_addr_log[wr0]), 32'h0b);
    chk("post_rst_data", 32'(wr_data_log[wr0]), 32'h7e);
    chk("post_rst_no_read", 32'(rd_cnt - rd0), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
